serial_compare: RTL
===================

Name: serial_compare

Overview:
- Bit-serial magnitude comparator for the 8-bit ALU comparator path.
- Accepts two WIDTH-bit unsigned operands over a valid/ready handshake and resolves them MSB-first, one bit per clock.
- Each bit step uses the existing bit_compare cell, with the skip inputs fed back from registered decision flags.
- Returns the a-greater, b-greater and equal result on an output valid/ready handshake; a low-area alternative to the parallel comparator chain.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a, b presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  unsigned operand A, sampled on acceptance
- b  input  WIDTH  unsigned operand B, sampled on acceptance
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- a_g  output  1  A > B
- b_g  output  1  B > A
- eq  output  1  A == B

Behaviour:
- One clock (clk). rst is asynchronous and active-high.
- Reset values: state IDLE; shift registers, bit counter, a_flag and b_flag all 0; out_valid, a_g, b_g and eq all 0; in_ready 1 (decoded from IDLE).
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high at a clock edge: load a_sr <= a and b_sr <= b; clear a_flag and b_flag; set cnt <= WIDTH-1; go to SHIFT.
- SHIFT:
  - in_ready = 0.
  - The bit_compare instance sees a_sr[WIDTH-1], b_sr[WIDTH-1], a_skip = a_flag and b_skip = b_flag.
  - Each edge: a_flag <= a_g_cell, b_flag <= b_g_cell; shift both registers left by 1 (zero fill); decrement cnt.
  - When cnt == 0 at the edge, go to DONE.
- DONE:
  - out_valid = 1; a_g = a_flag, b_g = b_flag, eq = ~a_flag & ~b_flag.
  - Outputs hold stable while out_ready is low.
  - When out_ready is high at an edge, go to IDLE. out_valid is 0 from the next cycle.
  - in_ready stays 0 in DONE, so there is no back-to-back overlap. Minimum initiation interval is WIDTH+1 cycles.
- Latency: out_valid is asserted exactly WIDTH clocks after the acceptance edge (without the optional feature).
- Invariant: a_flag and b_flag are never both 1. Once a flag is set, the skip input keeps it set for the rest of the operation.
- Outside DONE: out_valid = 0, and a_g, b_g, eq are driven 0.
- In SHIFT, in_valid is ignored; the operand is not consumed.
- Reset asserted mid-operation:
  - All state returns to reset values immediately (asynchronous). The in-flight compare is discarded with no result.
  - After rst deasserts, the first edge can accept new operands.
- out_ready high in IDLE or SHIFT has no effect.

Optional Feature:
- Macro: SERIAL_COMPARE_EARLY_EXIT_EN.
- Defined:
  - In SHIFT, if either updated flag becomes 1, go to DONE at that edge regardless of cnt.
  - Latency = k+1 cycles, where k is the index from the MSB (0-based) of the first differing bit.
  - Equal operands still take WIDTH cycles.
- Not defined: fixed WIDTH-cycle latency; the flags only freeze the result.

Decomposition:
- Package comparator_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - localparam function for the counter width, $clog2(WIDTH);
  - packed struct cmp_result_t {a_g, b_g, eq}.
- Sub-module: the existing bit_compare cell, instantiated once as the per-bit step. No other sub-modules.

Test Plan:
- Reset, then a=8'h00, b=8'h00 -> out_valid after 8 cycles; a_g=0, b_g=0, eq=1.
- a=8'h80, b=8'h7F -> a_g=1, b_g=0, eq=0.
  - Without the macro: latency 8.
  - With SERIAL_COMPARE_EARLY_EXIT_EN: latency 1.
- a=8'h12, b=8'h13 (differ at LSB only) -> b_g=1, latency 8 with or without the macro.
- Backpressure: a=8'hA5, b=8'h5A, out_ready held 0 for 5 cycles -> out_valid, a_g=1 stable throughout; in_ready=0; IDLE one cycle after out_ready=1.
- Reset mid-operation: accept a=8'hFF, b=8'h00, pulse rst at cycle 3 -> out_valid and outputs 0 immediately, in_ready=1. Next operands a=8'h01, b=8'h02 -> b_g=1.
- Handshake: hold in_valid=1 with new operands during SHIFT -> not sampled. Second operand pair accepted only at the first IDLE edge after the DONE handshake.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM state, result bundle and
// the counter-width helper.
package comparator_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  typedef struct packed {
    logic a_g;
    logic b_g;
    logic eq;
  } cmp_result_t;

  function automatic int unsigned cnt_width(int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/bit_compare.sv
// One MSB-first comparison step. Once either skip input is set, that decision is held
// and the current bits are ignored.
module bit_compare (
  input  logic a_i,
  input  logic b_i,
  input  logic a_skip_i,
  input  logic b_skip_i,
  output logic a_g_o,
  output logic b_g_o
);

  always_comb begin
    a_g_o = a_skip_i | (~b_skip_i & a_i & ~b_i);
    b_g_o = b_skip_i | (~a_skip_i & ~a_i & b_i);
  end

endmodule

// File: rtl/serial_compare.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit per clock.
// Optional: SERIAL_COMPARE_EARLY_EXIT_EN finishes at the first differing bit.
module serial_compare
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_g,
  output logic             b_g,
  output logic             eq
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             a_flag_q, a_flag_d;
  logic             b_flag_q, b_flag_d;
  logic             cell_a_g, cell_b_g;
  cmp_result_t      res;

  bit_compare u_bit_compare (
    .a_i      (a_sr_q[WIDTH-1]),
    .b_i      (b_sr_q[WIDTH-1]),
    .a_skip_i (a_flag_q),
    .b_skip_i (b_flag_q),
    .a_g_o    (cell_a_g),
    .b_g_o    (cell_b_g)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      cnt_q    <= '0;
      a_flag_q <= 1'b0;
      b_flag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      cnt_q    <= cnt_d;
      a_flag_q <= a_flag_d;
      b_flag_q <= b_flag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    cnt_d    = cnt_q;
    a_flag_d = a_flag_q;
    b_flag_d = b_flag_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b;
          a_flag_d = 1'b0;
          b_flag_d = 1'b0;
          cnt_d    = CntW'(WIDTH - 1);
          state_d  = StShift;
        end
      end
      StShift: begin
        a_flag_d = cell_a_g;
        b_flag_d = cell_b_g;
        a_sr_d   = {a_sr_q[WIDTH-2:0], 1'b0};
        b_sr_d   = {b_sr_q[WIDTH-2:0], 1'b0};
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = StDone;
        end
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
        if (cell_a_g || cell_b_g) begin
          state_d = StDone;
        end
`endif
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    res       = '0;
    if (state_q == StDone) begin
      res.a_g = a_flag_q;
      res.b_g = b_flag_q;
      res.eq  = ~a_flag_q & ~b_flag_q;
    end
    a_g = res.a_g;
    b_g = res.b_g;
    eq  = res.eq;
  end

endmodule
